// File: rtl/tia_pkg.sv
// Shared constants, types and the playfield bit-selection helper for the TIA playfield slice.
package tia_pkg;

  // Horizontal timing in color clocks: 68 blank clocks, then 160 visible.
  localparam logic [7:0] HCOUNT_MAX      = 8'd227;
  localparam logic [7:0] HBLANK_END      = 8'd68;
  localparam logic [5:0] PF_PIXELS       = 6'd40;
  localparam int         PF_CLKS_PER_BIT = 4;

  // Derived values: pixels per half-line and the shift that divides by bit width.
  localparam logic [5:0] PF_HALF      = PF_PIXELS >> 1;
  localparam int         PF_BIT_SHIFT = $clog2(PF_CLKS_PER_BIT);

  // Registered pixel-stage outputs, grouped so reset and update stay in one place.
  typedef struct packed {
    logic pf;
    logic cntd;
    logic blank;
  } pix_out_t;

  localparam pix_out_t PIX_OUT_RESET = '{pf: 1'b0, cntd: 1'b0, blank: 1'b1};

  // Picks the playfield bit for half-line index 0..19 in left-half order:
  // PF0[4..7], PF1[7..0], PF2[0..7]. PF0 is stored as its upper nibble only.
  function automatic logic pf_bit(input logic [3:0] pf0, input logic [7:0] pf1,
                                  input logic [7:0] pf2, input logic [4:0] idx);
    logic b;
    b = 1'b0;
    if (idx < 5'd4) begin
      b = pf0[idx[1:0]];
    end else if (idx < 5'd12) begin
      b = pf1[3'(5'd11 - idx)];
    end else if (idx < 5'd20) begin
      b = pf2[3'(idx - 5'd12)];
    end
    return b;
  endfunction

endpackage

// File: rtl/tia_hcounter.sv
// Horizontal color-clock counter: 0..227 with wrap and RSYNC (hrst) clear.
module tia_hcounter
  import tia_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hrst,
  output logic [7:0] hpos
);

  // Count every clock; reset and RSYNC both restart the line, RSYNC beats the wrap.
  always_ff @(posedge clk) begin
    if (rst || hrst) begin
      hpos <= 8'd0;
    end else if (hpos == HCOUNT_MAX) begin
      hpos <= 8'd0;
    end else begin
      hpos <= hpos + 8'd1;
    end
  end

endmodule

// File: rtl/tia_playfield.sv
// TIA playfield: PF0/PF1/PF2 and CTRLPF latches, a combinational bit-selection
// mux driven by the horizontal counter, and one output register stage.
module tia_playfield
  import tia_pkg::*;
(
  input  logic       clkp,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       pf0ci,
  input  logic       pf1ci,
  input  logic       pf2ci,
  input  logic       ctrlci,
  input  logic       hrst,
  output logic       pf,
  output logic       cntd,
  output logic       blank,
  output logic       score_bar,
  output logic       pfp_bar
);

  logic [7:0] hpos;
  logic [3:0] pf0;
  logic [7:0] pf1;
  logic [7:0] pf2;
  logic       mirror;
  logic       score;
  logic       prio;

  logic       visible;
  logic [5:0] pix;
  logic       right_half;
  logic [4:0] idx;
  pix_out_t   pix_next;
  pix_out_t   pix_q;

  tia_hcounter u_hcounter (
    .clk  (clkp),
    .rst  (rst),
    .hrst (hrst),
    .hpos (hpos)
  );

  // CPU-written registers; each strobe updates only its own register, reset wins.
  always_ff @(posedge clkp) begin
    if (rst) begin
      pf0    <= 4'd0;
      pf1    <= 8'd0;
      pf2    <= 8'd0;
      mirror <= 1'b0;
      score  <= 1'b0;
      prio   <= 1'b0;
    end else begin
      if (pf0ci) pf0 <= d[7:4];
      if (pf1ci) pf1 <= d;
      if (pf2ci) pf2 <= d;
      if (ctrlci) begin
        mirror <= d[0];
        score  <= d[1];
        prio   <= d[2];
      end
    end
  end

  // Map hpos to a playfield pixel and select its bit; right half may be mirrored.
  always_comb begin
    visible    = (hpos >= HBLANK_END);
    pix        = 6'((hpos - HBLANK_END) >> PF_BIT_SHIFT);
    right_half = (pix >= PF_HALF);
    if (!right_half) begin
      idx = 5'(pix);
    end else if (mirror) begin
      idx = 5'(PF_PIXELS - 6'd1 - pix);
    end else begin
      idx = 5'(pix - PF_HALF);
    end
    pix_next.pf    = visible & pf_bit(pf0, pf1, pf2, idx);
    pix_next.cntd  = visible & right_half;
    pix_next.blank = ~visible;
  end

  // Single output register stage: outputs lag hpos by one clock.
  always_ff @(posedge clkp) begin
    if (rst) begin
      pix_q <= PIX_OUT_RESET;
    end else begin
      pix_q <= pix_next;
    end
  end

  assign pf        = pix_q.pf;
  assign cntd      = pix_q.cntd;
  assign blank     = pix_q.blank;
  assign score_bar = ~score;
  assign pfp_bar   = ~prio;

endmodule

// File: tb/tb_tia_playfield.sv
// Bench for tia_playfield: line-level reference model with an expected queue
// compared every cycle, plus directed scenarios with literal expectations.
module tb_tia_playfield;

  logic       clkp;
  logic       rst;
  logic [7:0] d;
  logic       pf0ci;
  logic       pf1ci;
  logic       pf2ci;
  logic       ctrlci;
  logic       hrst;
  logic       pf;
  logic       cntd;
  logic       blank;
  logic       score_bar;
  logic       pfp_bar;

  int n_checks = 0;
  int n_fail   = 0;

  tia_playfield dut (
    .clkp      (clkp),
    .rst       (rst),
    .d         (d),
    .pf0ci     (pf0ci),
    .pf1ci     (pf1ci),
    .pf2ci     (pf2ci),
    .ctrlci    (ctrlci),
    .hrst      (hrst),
    .pf        (pf),
    .cntd      (cntd),
    .blank     (blank),
    .score_bar (score_bar),
    .pfp_bar   (pfp_bar)
  );

  // ---------------- clock / reset ----------------
  initial clkp = 1'b0;
  always #5 clkp = ~clkp;

  // ---------------- reference model ----------------
  // Architectural state as the CPU sees it, plus the whole 40-pixel line built
  // from the register contents.
  logic [7:0] m_hpos = 8'd0;
  logic [7:0] m_pf0  = 8'd0;
  logic [7:0] m_pf1  = 8'd0;
  logic [7:0] m_pf2  = 8'd0;
  logic       m_ref  = 1'b0;
  logic       m_score = 1'b0;
  logic       m_pfp  = 1'b0;
  logic       m_line [0:39];
  logic [4:0] exp_q [$];

  task automatic build_line();
    int n;
    n = 0;
    for (int b = 4; b < 8; b++) begin m_line[n] = m_pf0[b]; n = n + 1; end
    for (int b = 7; b >= 0; b--) begin m_line[n] = m_pf1[b]; n = n + 1; end
    for (int b = 0; b < 8; b++) begin m_line[n] = m_pf2[b]; n = n + 1; end
    for (int k = 0; k < 20; k++) m_line[20 + k] = m_ref ? m_line[19 - k] : m_line[k];
  endtask

  always @(posedge clkp) begin
    logic e_pf, e_cntd, e_blank;
    int   p;
    if (rst) begin
      e_pf = 1'b0; e_cntd = 1'b0; e_blank = 1'b1;
      m_hpos = 8'd0; m_pf0 = 8'd0; m_pf1 = 8'd0; m_pf2 = 8'd0;
      m_ref = 1'b0; m_score = 1'b0; m_pfp = 1'b0;
    end else begin
      build_line();
      if (m_hpos < 68) begin
        e_pf = 1'b0; e_cntd = 1'b0; e_blank = 1'b1;
      end else begin
        p = (int'(m_hpos) - 68) / 4;
        e_pf = m_line[p]; e_cntd = (p >= 20); e_blank = 1'b0;
      end
      if (pf0ci) m_pf0 = {d[7:4], 4'd0};
      if (pf1ci) m_pf1 = d;
      if (pf2ci) m_pf2 = d;
      if (ctrlci) begin m_ref = d[0]; m_score = d[1]; m_pfp = d[2]; end
      m_hpos = hrst ? 8'd0 : 8'((int'(m_hpos) + 1) % 228);
    end
    exp_q.push_back({e_pf, e_cntd, e_blank, ~m_score, ~m_pfp});
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clkp) begin
    logic [4:0] e;
    logic [4:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pf, cntd, blank, score_bar, pfp_bar};
      n_checks = n_checks + 1;
      if (a !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL cycle_outputs t=%0t: {pf,cntd,blank,score_bar,pfp_bar} got %b expected %b", $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic line_rec [0:227];

  task automatic tick();
    @(posedge clkp);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic s0, input logic s1, input logic s2, input logic sc,
                    input logic [7:0] data);
    d = data; pf0ci = s0; pf1ci = s1; pf2ci = s2; ctrlci = sc;
    tick();
    d = 8'd0; pf0ci = 1'b0; pf1ci = 1'b0; pf2ci = 1'b0; ctrlci = 1'b0;
  endtask

  // Record pf for n clocks, indexed by the hpos each sample belongs to.
  task automatic run_line(input int n);
    for (int i = 0; i < n; i++) begin
      int h;
      h = int'(m_hpos);
      tick();
      line_rec[h] = pf;
    end
  endtask

  task automatic wait_hpos(input logic [7:0] target);
    for (int i = 0; i < 300 && m_hpos != target; i++) tick();
    check("wait_hpos_bound", m_hpos, target);
  endtask

  function automatic int count_ones();
    int c;
    c = 0;
    for (int i = 0; i < 228; i++) if (line_rec[i] === 1'b1) c = c + 1;
    return c;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int blank_ones, pf_ones, blank_fall, cntd_rise;
    rst = 1'b1; d = 8'd0; pf0ci = 1'b0; pf1ci = 1'b0; pf2ci = 1'b0;
    ctrlci = 1'b0; hrst = 1'b0;
    tick(); tick(); tick();
    check("reset_pf", pf, 0);
    check("reset_cntd", cntd, 0);
    check("reset_blank", blank, 1);
    check("reset_score_bar", score_bar, 1);
    check("reset_pfp_bar", pfp_bar, 1);
    rst = 1'b0;

    // Empty line: 68 blank clocks, then 160 visible, cntd 80 clocks into visible.
    blank_ones = 0; pf_ones = 0; blank_fall = -1; cntd_rise = -1;
    for (int k = 1; k <= 228; k++) begin
      tick();
      if (blank) blank_ones++;
      if (pf) pf_ones++;
      if (!blank && blank_fall < 0) blank_fall = k;
      if (cntd && cntd_rise < 0) cntd_rise = k;
    end
    check("empty_blank_clocks", 8'(blank_ones), 8'd68);
    check("empty_pf_ones", 8'(pf_ones), 8'd0);
    check("empty_cntd_delay", 8'(cntd_rise - blank_fall), 8'd80);

    // PF0 bit 4 only: pixel 0 in both halves.
    wr(1, 0, 0, 0, 8'h10);
    run_line(228);
    check("pf0_ones", 8'(count_ones()), 8'd8);
    check("pf0_h67", line_rec[67], 0);
    check("pf0_h68", line_rec[68], 1);
    check("pf0_h71", line_rec[71], 1);
    check("pf0_h72", line_rec[72], 0);
    check("pf0_h148", line_rec[148], 1);
    check("pf0_h152", line_rec[152], 0);

    // PF2 bit 7 with reflect: the two centre pixels.
    wr(1, 0, 0, 0, 8'h00);
    wr(0, 0, 1, 0, 8'h80);
    wr(0, 0, 0, 1, 8'h01);
    run_line(228);
    check("refl_ones", 8'(count_ones()), 8'd8);
    check("refl_h143", line_rec[143], 0);
    check("refl_h144", line_rec[144], 1);
    check("refl_h151", line_rec[151], 1);
    check("refl_h152", line_rec[152], 0);

    // CTRLPF score / priority, no extra latency.
    wr(0, 0, 0, 1, 8'h06);
    check("ctrl_score_bar_set", score_bar, 0);
    check("ctrl_pfp_bar_set", pfp_bar, 0);
    wr(0, 0, 0, 1, 8'h00);
    check("ctrl_score_bar_clr", score_bar, 1);
    check("ctrl_pfp_bar_clr", pfp_bar, 1);

    // RSYNC at hpos 100, then reset mid-line with strobes and hrst also high.
    wait_hpos(8'd100);
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
    check("hrst_blank_prev", blank, 0);
    tick();
    check("hrst_blank_after", blank, 1);
    wr(0, 1, 0, 0, 8'hFF);
    wait_hpos(8'd100);
    tick();
    check("pf1ff_h100", pf, 1);
    rst = 1'b1; hrst = 1'b1; pf0ci = 1'b1; d = 8'hFF;
    tick(); tick();
    rst = 1'b0; hrst = 1'b0; pf0ci = 1'b0; d = 8'h00;
    check("rst_mid_pf", pf, 0);
    check("rst_mid_blank", blank, 1);
    run_line(228);
    check("rst_cleared_ones", 8'(count_ones()), 8'd0);

    // PF1=0xAA written mid-pixel at hpos 84.
    wait_hpos(8'd84);
    wr(0, 1, 0, 0, 8'hAA);
    check("aa_h84_old", pf, 0);
    run_line(31);
    check("aa_h85", line_rec[85], 1);
    check("aa_h87", line_rec[87], 1);
    check("aa_h88", line_rec[88], 0);
    check("aa_h92", line_rec[92], 1);
    check("aa_h99", line_rec[99], 0);
    check("aa_h108", line_rec[108], 1);
    check("aa_h112", line_rec[112], 0);

    // Simultaneous PF0 and PF2 strobes with one data value.
    wr(1, 0, 1, 0, 8'h81);
    run_line(228);
    check("simul_ones", 8'(count_ones()), 8'd56);
    check("simul_h79", line_rec[79], 0);
    check("simul_h80", line_rec[80], 1);
    check("simul_h116", line_rec[116], 1);
    check("simul_h147", line_rec[147], 1);
    check("simul_h227", line_rec[227], 1);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
